mem_loader: RTL

//   Bus initiator that fills the banked data memory (bmemory data port) from a byte stream.

---
 rtl/mem_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/mem_loader.sv
// mem_loader: packs a byte stream little-endian into 32-bit words and writes them to memory,
// finishing a partial tail word by read-modify-write and optionally reading each word back.
module mem_loader #(
   parameter int CW     = 16,
   parameter bit VERIFY = 1'b1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic [31:0]   base,
   input  logic [CW-1:0] count,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic [31:0]   maddr,
   output logic          wenable,
   output logic [31:0]   wdata,
   output logic          renable,
   input  logic [31:0]   rdata,
   input  logic          m_ok,
   output logic          busy,
   output logic          done,
   output logic          error
);
   typedef enum logic [2:0] {IDLE, COLLECT, TAIL, WRITE, CHECK, DONE, ERR} state_t;
   state_t state, nxt;
   logic [31:0] addr, word;
   logic [CW-1:0] rem;
   logic [2:0] held, need;
   logic err_q, accept;
   always_comb begin
      need = (rem < CW'(4)) ? rem[2:0] : 3'd4;
      accept = in_valid && in_ready;
      busy = (state == COLLECT) || (state == TAIL) || (state == WRITE) || (state == CHECK);
      done = (state == DONE) || (state == ERR);
      error = err_q;
   end
   always_comb begin
      nxt = state;
      in_ready = 1'b0;
      maddr = '0;
      wdata = '0;
      wenable = 1'b0;
      renable = 1'b0;
      case (state)
         IDLE: if (start) nxt = (count != '0) ? COLLECT : DONE;
         COLLECT: begin
            in_ready = held < need;
            if (in_valid && (held < need) && (held + 3'd1 == need)) nxt = (need == 3'd4) ? WRITE : TAIL;
         end
         TAIL: begin
            renable = 1'b1;
            maddr = addr;
            nxt = m_ok ? WRITE : ERR;
         end
         WRITE: begin
            wenable = m_ok;
            maddr = addr;
            wdata = word;
            nxt = !m_ok ? ERR : VERIFY ? CHECK : (rem <= CW'(4)) ? DONE : COLLECT;
         end
         CHECK: begin
            renable = 1'b1;
            maddr = addr - 32'd4;
            nxt = (!m_ok || rdata != word) ? ERR : (rem == '0) ? DONE : COLLECT;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         addr <= '0;
         rem <= '0;
         word <= '0;
         held <= '0;
         err_q <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && start && count != '0) begin
            addr <= base;
            rem <= count;
            held <= '0;
            err_q <= 1'b0;
         end
         if (accept) begin
            word[{held[1:0], 3'b000} +: 8] <= in_data;
            held <= held + 3'd1;
         end
         // bytes beyond the stream tail keep the current memory contents
         if (state == TAIL)
            for (int k = 0; k < 4; k++)
               if (3'(k) >= need) word[8*k +: 8] <= rdata[8*k +: 8];
         if (state == WRITE && m_ok) begin
            addr <= addr + 32'd4;
            rem <= rem - CW'(need);
            held <= '0;
         end
         if (nxt == ERR) err_q <= 1'b1;
      end
   end
endmodule
